// File: rtl/maquina_necesidad_param_pkg.sv
// Shared definitions for the pet food-need state machine: state codes, state width
// and the test-mode stepping order. Also used by the display/7-seg formatter.
package maquina_necesidad_param_pkg;

  localparam int ESTADO_W = 3;

  localparam logic [2:0] ESTADO_IDLE       = 3'b000;
  localparam logic [2:0] ESTADO_HAMBRE     = 3'b001;
  localparam logic [2:0] ESTADO_DESNUTRIDO = 3'b010;
  localparam logic [2:0] ESTADO_COMIENDO   = 3'b011;

  // Test-mode walk: IDLE -> HAMBRE -> DESNUTRIDO -> COMIENDO -> IDLE; invalid codes recover to IDLE.
  function automatic logic [ESTADO_W-1:0] siguiente_test(input logic [ESTADO_W-1:0] e);
    logic [ESTADO_W-1:0] s;
    case (e)
      ESTADO_IDLE:       s = ESTADO_HAMBRE;
      ESTADO_HAMBRE:     s = ESTADO_DESNUTRIDO;
      ESTADO_DESNUTRIDO: s = ESTADO_COMIENDO;
      ESTADO_COMIENDO:   s = ESTADO_IDLE;
      default:           s = ESTADO_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/maquina_necesidad_param_detector_flanco.sv
// 1-bit registered rising-edge detector. The pulse is registered, so it appears
// on the cycle after the edge is sampled. During reset the previous-value register
// tracks the input, so an edge arriving together with reset is absorbed and does
// not reappear as a pulse afterwards.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic pulso_o
);

  logic prev_q;
  logic pulso_q;

  // Track previous input and register the rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= d_i;
      pulso_q <= 1'b0;
    end else begin
      prev_q  <= d_i;
      pulso_q <= d_i & ~prev_q;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/maquina_necesidad_param.sv
// Pet food-need state machine. Owns the need level: it decays on a tick timer while
// not eating and refills on a faster timer while eating. State and level drive the
// display formatter and the button-enable logic of the pet top level.
// Optional build macro MAQUINA_TEST_MODE_EN adds a test stepper: while senal_mtest
// is high, level and timers freeze, the feed button is ignored and each rising edge
// of senal_test advances the state by one and bumps paso_test.
module maquina_necesidad_param
  import maquina_necesidad_param_pkg::*;
#(
  parameter int LEVEL_W       = 3,
  parameter int LEVEL_MAX     = 7,
  parameter int TH_HAMBRE     = 4,
  parameter int TH_DESNUTRIDO = 1,
  parameter int DECAY_TICKS   = 50_000_000,
  parameter int FEED_TICKS    = 25_000_000,
  parameter int TICK_W        = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               boton_comida,
  input  logic               senal_mtest,
  input  logic               senal_test,
  output logic [LEVEL_W-1:0] nivel,
  output logic [ESTADO_W-1:0] estado,
  output logic               activo_comida,
  output logic               evento_cambio,
  output logic [1:0]         paso_test
);

  // Thresholds narrowed to the level width so every compare is LEVEL_W unsigned.
  localparam logic [LEVEL_W-1:0] NIVEL_MAX_L  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] TH_HAMBRE_L  = LEVEL_W'(TH_HAMBRE);
  localparam logic [LEVEL_W-1:0] TH_DESNUT_L  = LEVEL_W'(TH_DESNUTRIDO);
  localparam logic [LEVEL_W-1:0] NIVEL_CERO_L = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] NIVEL_UNO_L  = LEVEL_W'(1);
  localparam logic [TICK_W-1:0]  CNT_CERO_L   = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0]  CNT_UNO_L    = TICK_W'(1);
  localparam logic [TICK_W-1:0]  DECAY_FIN_L  = TICK_W'(DECAY_TICKS - 1);
  localparam logic [TICK_W-1:0]  FEED_FIN_L   = TICK_W'(FEED_TICKS - 1);

  logic [ESTADO_W-1:0] estado_q, estado_d;
  logic [LEVEL_W-1:0]  nivel_q, nivel_d;
  logic [TICK_W-1:0]   decay_cnt_q, decay_cnt_d;
  logic [TICK_W-1:0]   feed_cnt_q, feed_cnt_d;
  logic                activo_q;
  logic                evento_q;
  logic [1:0]          paso_q;

  logic modo_test_s;
  logic paso_test_s;

`ifdef MAQUINA_TEST_MODE_EN
  logic pulso_test_s;

  detector_flanco u_detector_flanco (
    .clk     (clk),
    .reset   (reset),
    .d_i     (senal_test),
    .pulso_o (pulso_test_s)
  );

  assign modo_test_s = senal_mtest;
  assign paso_test_s = senal_mtest & pulso_test_s;
`else
  logic unused_test_s;

  assign unused_test_s = senal_mtest ^ senal_test;
  assign modo_test_s   = 1'b0;
  assign paso_test_s   = 1'b0;
`endif

  // Next-state selection on the registered level and current inputs.
  always_comb begin
    estado_d = estado_q;
    if (modo_test_s) begin
      if (paso_test_s) begin
        estado_d = siguiente_test(estado_q);
      end else if (estado_q > ESTADO_COMIENDO) begin
        estado_d = ESTADO_IDLE;
      end else begin
        estado_d = estado_q;
      end
    end else begin
      case (estado_q)
        ESTADO_IDLE: begin
          if (nivel_q < TH_HAMBRE_L) estado_d = ESTADO_HAMBRE;
          else                       estado_d = ESTADO_IDLE;
        end
        ESTADO_HAMBRE: begin
          // Starvation outranks feeding.
          if (nivel_q < TH_DESNUT_L)       estado_d = ESTADO_DESNUTRIDO;
          else if (boton_comida)           estado_d = ESTADO_COMIENDO;
          else if (nivel_q >= TH_HAMBRE_L) estado_d = ESTADO_IDLE;
          else                             estado_d = ESTADO_HAMBRE;
        end
        ESTADO_DESNUTRIDO: begin
          if (boton_comida) estado_d = ESTADO_COMIENDO;
          else              estado_d = ESTADO_DESNUTRIDO;
        end
        ESTADO_COMIENDO: begin
          // A full pet stops eating even with the button held.
          if (nivel_q == NIVEL_MAX_L)      estado_d = ESTADO_IDLE;
          else if (boton_comida)           estado_d = ESTADO_COMIENDO;
          else if (nivel_q >= TH_HAMBRE_L) estado_d = ESTADO_IDLE;
          else if (nivel_q >= TH_DESNUT_L) estado_d = ESTADO_HAMBRE;
          else                             estado_d = ESTADO_DESNUTRIDO;
        end
        default: estado_d = ESTADO_IDLE;
      endcase
    end
  end

  // Decay / refill timers and the saturating level update, driven by the current state.
  always_comb begin
    nivel_d     = nivel_q;
    decay_cnt_d = decay_cnt_q;
    feed_cnt_d  = feed_cnt_q;
    if (modo_test_s) begin
      nivel_d     = nivel_q;
      decay_cnt_d = decay_cnt_q;
      feed_cnt_d  = feed_cnt_q;
    end else if (estado_q == ESTADO_COMIENDO) begin
      decay_cnt_d = CNT_CERO_L;
      if (feed_cnt_q == FEED_FIN_L) begin
        feed_cnt_d = CNT_CERO_L;
        if (nivel_q < NIVEL_MAX_L) nivel_d = nivel_q + NIVEL_UNO_L;
        else                       nivel_d = nivel_q;
      end else begin
        feed_cnt_d = feed_cnt_q + CNT_UNO_L;
      end
    end else begin
      // Any non-eating state decays; leaving COMIENDO clears the refill timer.
      feed_cnt_d = CNT_CERO_L;
      if (decay_cnt_q == DECAY_FIN_L) begin
        decay_cnt_d = CNT_CERO_L;
        if (nivel_q != NIVEL_CERO_L) nivel_d = nivel_q - NIVEL_UNO_L;
        else                         nivel_d = nivel_q;
      end else begin
        decay_cnt_d = decay_cnt_q + CNT_UNO_L;
      end
    end
  end

  // State, level, timers and all outputs registered together; reset aborts any refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= ESTADO_IDLE;
      nivel_q     <= NIVEL_MAX_L;
      decay_cnt_q <= CNT_CERO_L;
      feed_cnt_q  <= CNT_CERO_L;
      activo_q    <= 1'b1;
      evento_q    <= 1'b0;
      paso_q      <= 2'd0;
    end else begin
      estado_q    <= estado_d;
      nivel_q     <= nivel_d;
      decay_cnt_q <= decay_cnt_d;
      feed_cnt_q  <= feed_cnt_d;
      activo_q    <= (estado_d != ESTADO_COMIENDO);
      evento_q    <= (estado_d != estado_q);
      if (paso_test_s) paso_q <= paso_q + 2'd1;
      else             paso_q <= paso_q;
    end
  end

  assign nivel         = nivel_q;
  assign estado        = estado_q;
  assign activo_comida = activo_q;
  assign evento_cambio = evento_q;
  assign paso_test     = paso_q;

endmodule

// File: tb/tb_maquina_necesidad_param.sv
// Self-checking bench for maquina_necesidad_param with short tick counts.
// Directed scenarios plus a randomized run against a behavioural reference model.
module tb_maquina_necesidad_param;

  localparam int LW   = 3;
  localparam int LMAX = 7;
  localparam int THH  = 4;
  localparam int THD  = 1;
  localparam int DT   = 4;
  localparam int FT   = 2;
`ifdef MAQUINA_TEST_MODE_EN
  localparam bit TEST_EN = 1'b1;
`else
  localparam bit TEST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          boton_comida = 1'b0;
  logic          senal_mtest = 1'b0;
  logic          senal_test = 1'b0;
  logic [LW-1:0] nivel;
  logic [2:0]    estado;
  logic          activo_comida;
  logic          evento_cambio;
  logic [1:0]    paso_test;

  maquina_necesidad_param #(
    .LEVEL_W(LW), .LEVEL_MAX(LMAX), .TH_HAMBRE(THH), .TH_DESNUTRIDO(THD),
    .DECAY_TICKS(DT), .FEED_TICKS(FT), .TICK_W(26)
  ) dut (
    .clk(clk), .reset(reset), .boton_comida(boton_comida), .senal_mtest(senal_mtest),
    .senal_test(senal_test), .nivel(nivel), .estado(estado), .activo_comida(activo_comida),
    .evento_cambio(evento_cambio), .paso_test(paso_test)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pet condition after each clock edge.
  // States: 0 idle, 1 hungry, 2 malnourished, 3 eating.
  int m_estado, m_nivel, m_dcnt, m_fcnt, m_activo, m_evento, m_paso;
  bit m_prev, m_edge_seen;

  function automatic void model_step();
    int ns;
    bit fire, freeze;
    if (reset) begin
      m_estado = 0; m_nivel = LMAX; m_dcnt = 0; m_fcnt = 0;
      m_activo = 1; m_evento = 0; m_paso = 0;
      m_prev = senal_test; m_edge_seen = 1'b0;
    end else begin
      freeze = TEST_EN && senal_mtest;
      fire   = freeze && m_edge_seen;
      m_edge_seen = TEST_EN && senal_test && !m_prev;
      m_prev = senal_test;
      if (freeze) begin
        ns = fire ? (m_estado + 1) % 4 : m_estado;
      end else begin
        ns = m_estado;
        if (m_estado == 0) begin
          if (m_nivel < THH) ns = 1;
        end else if (m_estado == 1) begin
          if (m_nivel < THD) ns = 2;
          else if (boton_comida) ns = 3;
          else if (m_nivel >= THH) ns = 0;
        end else if (m_estado == 2) begin
          if (boton_comida) ns = 3;
        end else begin
          if (m_nivel == LMAX) ns = 0;
          else if (boton_comida) ns = 3;
          else if (m_nivel >= THH) ns = 0;
          else if (m_nivel >= THD) ns = 1;
          else ns = 2;
        end
        if (m_estado == 3) begin
          m_dcnt = 0;
          m_fcnt++;
          if (m_fcnt == FT) begin m_fcnt = 0; if (m_nivel < LMAX) m_nivel++; end
        end else begin
          m_fcnt = 0;
          m_dcnt++;
          if (m_dcnt == DT) begin m_dcnt = 0; if (m_nivel > 0) m_nivel--; end
        end
      end
      m_evento = (ns != m_estado);
      m_activo = (ns != 3);
      if (fire) m_paso = (m_paso + 1) % 4;
      m_estado = ns;
    end
  endfunction

  // Advance one clock: model consumes the inputs the DUT samples at the next posedge.
  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; boton_comida = 1'b0; senal_mtest = 1'b0; senal_test = 1'b0;
    tick(); tick();
    n_checks++; if (estado !== 3'd0) begin n_fail++; $display("FAIL reset_estado: got %0d expected 0", estado); end
    n_checks++; if (nivel !== 3'd7) begin n_fail++; $display("FAIL reset_nivel: got %0d expected 7", nivel); end
    n_checks++; if (activo_comida !== 1'b1) begin n_fail++; $display("FAIL reset_activo: got %0b expected 1", activo_comida); end
    n_checks++; if (paso_test !== 2'd0) begin n_fail++; $display("FAIL reset_paso: got %0d expected 0", paso_test); end
    n_checks++; if (evento_cambio !== 1'b0) begin n_fail++; $display("FAIL reset_evento: got %0b expected 0", evento_cambio); end
    reset = 1'b0;
  endtask

  task automatic test_decay();
    repeat (16) tick();
    n_checks++; if (nivel !== 3'd3) begin n_fail++; $display("FAIL decay16_nivel: got %0d expected 3", nivel); end
    n_checks++; if (estado !== 3'd0) begin n_fail++; $display("FAIL decay16_estado: got %0d expected 0", estado); end
    tick();
    n_checks++; if (estado !== 3'd1) begin n_fail++; $display("FAIL hambre_estado: got %0d expected 1", estado); end
    n_checks++; if (evento_cambio !== 1'b1) begin n_fail++; $display("FAIL hambre_evento: got %0b expected 1", evento_cambio); end
    tick();
    n_checks++; if (evento_cambio !== 1'b0) begin n_fail++; $display("FAIL evento_pulse_width: got %0b expected 0", evento_cambio); end
    for (int i = 0; i < 40 && estado !== 3'd2; i++) tick();
    n_checks++; if (estado !== 3'd2) begin n_fail++; $display("FAIL desnutrido_estado: got %0d expected 2", estado); end
    n_checks++; if (nivel !== 3'd0) begin n_fail++; $display("FAIL desnutrido_nivel: got %0d expected 0", nivel); end
    repeat (8) tick();
    n_checks++; if (nivel !== 3'd0) begin n_fail++; $display("FAIL nivel_floor: got %0d expected 0", nivel); end
    n_checks++; if (estado !== 3'd2) begin n_fail++; $display("FAIL desnutrido_hold: got %0d expected 2", estado); end
  endtask

  task automatic test_feed();
    boton_comida = 1'b1;
    tick();
    n_checks++; if (estado !== 3'd3) begin n_fail++; $display("FAIL feed_estado: got %0d expected 3", estado); end
    n_checks++; if (activo_comida !== 1'b0) begin n_fail++; $display("FAIL feed_activo: got %0b expected 0", activo_comida); end
    tick(); tick();
    n_checks++; if (nivel !== 3'd1) begin n_fail++; $display("FAIL feed_rate: got %0d expected 1", nivel); end
    for (int i = 0; i < 30 && nivel !== 3'd7; i++) tick();
    n_checks++; if (nivel !== 3'd7) begin n_fail++; $display("FAIL feed_full_nivel: got %0d expected 7", nivel); end
    n_checks++; if (estado !== 3'd3) begin n_fail++; $display("FAIL feed_full_estado: got %0d expected 3", estado); end
    tick();
    n_checks++; if (estado !== 3'd0) begin n_fail++; $display("FAIL full_exit_estado: got %0d expected 0", estado); end
    n_checks++; if (activo_comida !== 1'b1) begin n_fail++; $display("FAIL full_exit_activo: got %0b expected 1", activo_comida); end
    n_checks++; if (nivel !== 3'd7) begin n_fail++; $display("FAIL full_saturate: got %0d expected 7", nivel); end
  endtask

  task automatic test_eat_release();
    boton_comida = 1'b0;
    for (int i = 0; i < 40 && nivel !== 3'd1; i++) tick();
    n_checks++; if (estado !== 3'd1) begin n_fail++; $display("FAIL nivel1_estado: got %0d expected 1", estado); end
    boton_comida = 1'b1;
    tick();
    n_checks++; if (estado !== 3'd3) begin n_fail++; $display("FAIL hambre_to_comer: got %0d expected 3", estado); end
    for (int i = 0; i < 20 && nivel !== 3'd2; i++) tick();
    n_checks++; if (nivel !== 3'd2) begin n_fail++; $display("FAIL eat_to_2: got %0d expected 2", nivel); end
    boton_comida = 1'b0;
    tick();
    n_checks++; if (estado !== 3'd1) begin n_fail++; $display("FAIL release_estado: got %0d expected 1", estado); end
    n_checks++; if (activo_comida !== 1'b1) begin n_fail++; $display("FAIL release_activo: got %0b expected 1", activo_comida); end
  endtask

  task automatic test_test_mode();
    int e0, l0;
    e0 = int'(estado); l0 = int'(nivel);
    senal_mtest = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      senal_test = 1'b1; tick();
      senal_test = 1'b0; tick();
      if (TEST_EN) begin
        n_checks++; if (int'(estado) != (e0 + k) % 4) begin n_fail++; $display("FAIL step_estado_%0d: got %0d expected %0d", k, estado, (e0 + k) % 4); end
        n_checks++; if (int'(paso_test) != k % 4) begin n_fail++; $display("FAIL step_paso_%0d: got %0d expected %0d", k, paso_test, k % 4); end
        n_checks++; if (int'(nivel) != l0) begin n_fail++; $display("FAIL step_freeze_%0d: got %0d expected %0d", k, nivel, l0); end
      end else begin
        n_checks++; if (paso_test !== 2'd0) begin n_fail++; $display("FAIL paso_tied_%0d: got %0d expected 0", k, paso_test); end
        n_checks++; if (int'(estado) != m_estado) begin n_fail++; $display("FAIL mtest_ignored_%0d: got %0d expected %0d", k, estado, m_estado); end
      end
    end
    senal_mtest = 1'b0;
    tick();
    n_checks++; if (int'(estado) != m_estado) begin n_fail++; $display("FAIL mtest_exit_estado: got %0d expected %0d", estado, m_estado); end
  endtask

  task automatic test_reset_mid_feed();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 40 && nivel !== 3'd2; i++) tick();
    boton_comida = 1'b1;
    for (int i = 0; i < 20 && !(estado === 3'd3 && nivel === 3'd3); i++) tick();
    n_checks++; if (nivel !== 3'd3 || estado !== 3'd3) begin n_fail++; $display("FAIL mid_feed_setup: got estado %0d nivel %0d expected 3/3", estado, nivel); end
    reset = 1'b1;
    tick();
    reset = 1'b0; boton_comida = 1'b0;
    n_checks++; if (estado !== 3'd0) begin n_fail++; $display("FAIL midreset_estado: got %0d expected 0", estado); end
    n_checks++; if (nivel !== 3'd7) begin n_fail++; $display("FAIL midreset_nivel: got %0d expected 7", nivel); end
    n_checks++; if (activo_comida !== 1'b1) begin n_fail++; $display("FAIL midreset_activo: got %0b expected 1", activo_comida); end
    repeat (3) tick();
    n_checks++; if (nivel !== 3'd7) begin n_fail++; $display("FAIL midreset_decay3: got %0d expected 7", nivel); end
    tick();
    n_checks++; if (nivel !== 3'd6) begin n_fail++; $display("FAIL midreset_decay4: got %0d expected 6", nivel); end
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      n_checks++; if (int'(estado) != m_estado) begin n_fail++; $display("FAIL rnd_estado @%0d: got %0d expected %0d", i, estado, m_estado); end
      n_checks++; if (int'(nivel) != m_nivel) begin n_fail++; $display("FAIL rnd_nivel @%0d: got %0d expected %0d", i, nivel, m_nivel); end
      n_checks++; if (int'(activo_comida) != m_activo) begin n_fail++; $display("FAIL rnd_activo @%0d: got %0b expected %0d", i, activo_comida, m_activo); end
      n_checks++; if (int'(evento_cambio) != m_evento) begin n_fail++; $display("FAIL rnd_evento @%0d: got %0b expected %0d", i, evento_cambio, m_evento); end
      n_checks++; if (int'(paso_test) != m_paso) begin n_fail++; $display("FAIL rnd_paso @%0d: got %0d expected %0d", i, paso_test, m_paso); end
      if ($urandom_range(0, 14) == 0) boton_comida = ~boton_comida;
      if ($urandom_range(0, 39) == 0) senal_mtest = ~senal_mtest;
      if ($urandom_range(0, 2) == 0) senal_test = ~senal_test;
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0; senal_mtest = 1'b0; boton_comida = 1'b0; senal_test = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_decay();
    test_feed();
    test_eat_release();
    test_test_mode();
    test_reset_mid_feed();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
